// File: rtl/eth_fifo_pkg.sv
// Shared types for the 10G TX store-and-forward packet FIFO.
// One stored RAM word is a single AXIS beat: {tlast, tkeep, tdata}.
package eth_fifo_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic                   tlast;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic [AXIS_DATA_W-1:0] tdata;
  } axis_word_t;

  typedef enum logic {
    WR_STORE,
    WR_DROP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_SEND
  } rd_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM with one write port and a registered 1-cycle read port.
// There is deliberately no reset, so synthesis can map it onto block RAM.
module sdp_ram #(
  parameter int WIDTH  = 73,
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/eth_tx_pktfifo.sv
// Store-and-forward TX packet FIFO: frames are committed on a clean tlast and only
// then released to the MAC; overflowing or tuser-flagged frames are dropped.
module eth_tx_pktfifo
  import eth_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_W      = 32
) (
  input  logic                   clk156,
  input  logic                   reset_n,
  input  logic                   s_axis_tx_tvalid,
  output logic                   s_axis_tx_tready,
  input  logic [AXIS_DATA_W-1:0] s_axis_tx_tdata,
  input  logic [AXIS_KEEP_W-1:0] s_axis_tx_tkeep,
  input  logic                   s_axis_tx_tlast,
  input  logic                   s_axis_tx_tuser,
  output logic                   m_axis_tx_tvalid,
  input  logic                   m_axis_tx_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tx_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tx_tkeep,
  output logic                   m_axis_tx_tlast,
  output logic                   m_axis_tx_tuser,
  output logic [CNT_W-1:0]       stat_tx_frames,
  output logic [CNT_W-1:0]       stat_drop_frames
);

  localparam int AVAIL_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

  wr_state_t             wr_state_q;
  rd_state_t             rd_state_q;
  logic                  tready_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_commit_q, rd_ptr_q;
  logic [AVAIL_W-1:0]    frames_avail_q, frames_avail_d;
  logic [CNT_W-1:0]      tx_cnt_q, drop_cnt_q;

  axis_word_t            wr_word, ram_word, out_q, skid_q;
  logic                  out_vld_q, skid_vld_q, inflight_q;

  logic                  accept, full, ram_we, commit;
  logic [DEPTH_LOG2-1:0] wr_ptr_inc;
  logic                  pop, pop_last, rd_space, rd_issue, load_out;
  logic [1:0]            occ;

  assign accept     = s_axis_tx_tvalid & tready_q;
  assign wr_ptr_inc = wr_ptr_q + PTR_ONE;
  assign full       = (wr_ptr_inc == rd_ptr_q);
  assign ram_we     = accept && (wr_state_q == WR_STORE) && !full &&
                      !(s_axis_tx_tlast && s_axis_tx_tuser);
  assign commit     = ram_we && s_axis_tx_tlast;
  assign wr_word    = '{tlast: s_axis_tx_tlast, tkeep: s_axis_tx_tkeep, tdata: s_axis_tx_tdata};

  // Write side: wr_ptr runs ahead speculatively, wr_commit marks the last whole frame.
  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q  <= WR_STORE;
      tready_q    <= 1'b0;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      tready_q <= 1'b1;
      case (wr_state_q)
        WR_STORE: begin
          if (accept) begin
            if (full) begin
              wr_ptr_q <= wr_commit_q;
              if (s_axis_tx_tlast) drop_cnt_q <= drop_cnt_q + CNT_ONE;
              else                 wr_state_q <= WR_DROP;
            end else if (s_axis_tx_tlast && s_axis_tx_tuser) begin
              wr_ptr_q   <= wr_commit_q;
              drop_cnt_q <= drop_cnt_q + CNT_ONE;
            end else begin
              wr_ptr_q <= wr_ptr_inc;
              if (s_axis_tx_tlast) wr_commit_q <= wr_ptr_inc;
            end
          end
        end
        WR_DROP: begin
          if (accept && s_axis_tx_tlast) begin
            drop_cnt_q <= drop_cnt_q + CNT_ONE;
            wr_state_q <= WR_STORE;
          end
        end
        default: wr_state_q <= WR_STORE;
      endcase
    end
  end

  sdp_ram #(
    .WIDTH  ($bits(axis_word_t)),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk156),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_word),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_word)
  );

  assign pop            = out_vld_q & m_axis_tx_tready;
  assign pop_last       = pop & out_q.tlast;
  assign frames_avail_d = frames_avail_q + AVAIL_W'(commit) - AVAIL_W'(pop_last);

  // Entries held in out/skid plus the read in flight may never exceed two.
  assign occ      = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(inflight_q);
  assign rd_space = pop ? (occ <= 2'd2) : (occ <= 2'd1);
  assign rd_issue = (rd_ptr_q != wr_commit_q) && rd_space &&
                    ((rd_state_q == RD_SEND) || (frames_avail_q != '0));
  assign load_out = !out_vld_q || pop;

  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q     <= RD_IDLE;
      rd_ptr_q       <= '0;
      frames_avail_q <= '0;
      tx_cnt_q       <= '0;
      inflight_q     <= 1'b0;
    end else begin
      frames_avail_q <= frames_avail_d;
      inflight_q     <= rd_issue;
      if (rd_issue) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (pop_last) tx_cnt_q <= tx_cnt_q + CNT_ONE;
      case (rd_state_q)
        RD_IDLE: if (frames_avail_q != '0) rd_state_q <= RD_SEND;
        RD_SEND: if (pop_last && (frames_avail_d == '0)) rd_state_q <= RD_IDLE;
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Output register with one-entry skid: the RAM result lands in whichever is free.
  always_ff @(posedge clk156 or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (load_out) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= inflight_q;
        if (inflight_q) skid_q <= ram_word;
      end else if (inflight_q) begin
        out_q     <= ram_word;
        out_vld_q <= 1'b1;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (inflight_q) begin
      skid_q     <= ram_word;
      skid_vld_q <= 1'b1;
    end
  end

  assign s_axis_tx_tready = tready_q;
  assign m_axis_tx_tvalid = out_vld_q;
  assign m_axis_tx_tdata  = out_q.tdata;
  assign m_axis_tx_tkeep  = out_q.tkeep;
  assign m_axis_tx_tlast  = out_q.tlast;
  assign m_axis_tx_tuser  = 1'b0;
  assign stat_tx_frames   = tx_cnt_q;
  assign stat_drop_frames = drop_cnt_q;

endmodule

// File: tb/tb_eth_tx_pktfifo.sv
// Directed bench for eth_tx_pktfifo with a 16-word buffer so overflow is reachable.
module tb_eth_tx_pktfifo;

  localparam int DL = 4;
  localparam int CW = 32;

  logic          clk156 = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [63:0]   s_tdata = '0;
  logic [7:0]    s_tkeep = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [63:0]   m_tdata;
  logic [7:0]    m_tkeep;
  logic          m_tlast;
  logic          m_tuser;
  logic [CW-1:0] stat_tx;
  logic [CW-1:0] stat_drop;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [72:0]   got_q[$];
  int            hs_cyc_q[$];
  logic [72:0]   exp_q[$];
  int            cyc = 0;
  int            stall_bad = 0;
  logic          hold_pend = 1'b0;
  logic [73:0]   hold_val = '0;
  logic          sready_watch = 1'b0;
  logic          sready_low = 1'b0;
  logic          rdy_rand = 1'b0;
  logic          rdy_fixed = 1'b1;

  eth_tx_pktfifo #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
    .clk156           (clk156),
    .reset_n          (reset_n),
    .s_axis_tx_tvalid (s_tvalid),
    .s_axis_tx_tready (s_tready),
    .s_axis_tx_tdata  (s_tdata),
    .s_axis_tx_tkeep  (s_tkeep),
    .s_axis_tx_tlast  (s_tlast),
    .s_axis_tx_tuser  (s_tuser),
    .m_axis_tx_tvalid (m_tvalid),
    .m_axis_tx_tready (m_tready),
    .m_axis_tx_tdata  (m_tdata),
    .m_axis_tx_tkeep  (m_tkeep),
    .m_axis_tx_tlast  (m_tlast),
    .m_axis_tx_tuser  (m_tuser),
    .stat_tx_frames   (stat_tx),
    .stat_drop_frames (stat_drop)
  );

  always #3 clk156 = ~clk156;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] beat(input int seed, input int i, input int n, input logic [7:0] lk);
    logic last;
    last = (i == n - 1);
    return {last, (last ? lk : 8'hFF), 16'(seed), 16'(i), 32'hC0DE0000 ^ 32'(seed * 256 + i)};
  endfunction

  task automatic drive_beat(input logic [72:0] b, input logic bad);
    s_tvalid = 1'b1;
    s_tlast  = b[72];
    s_tkeep  = b[71:64];
    s_tdata  = b[63:0];
    s_tuser  = bad & b[72];
    @(posedge clk156);
    #1;
  endtask

  task automatic send_frame(input int seed, input int n, input logic [7:0] lk,
                            input logic bad, input logic expd);
    logic [72:0] b;
    for (int i = 0; i < n; i++) begin
      b = beat(seed, i, n, lk);
      if (expd) exp_q.push_back(b);
      drive_beat(b, bad);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_out(input int base, input int n);
    int budget;
    budget = 400;
    while ((got_q.size() < base + n) && (budget > 0)) begin
      @(posedge clk156);
      budget--;
    end
    repeat (4) @(posedge clk156);
    #1;
  endtask

  task automatic cmp_frames(input string tag, input int base);
    chk({tag, "_cnt"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        chk($sformatf("%s_b%0d", tag, i), got_q[base + i], exp_q[i]);
  endtask

  // Ready generator: fixed level or a coin toss per cycle.
  initial forever begin
    @(posedge clk156);
    #1;
    m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Output monitor: sampled mid-cycle, records beats that will handshake at the next edge.
  initial forever begin
    @(negedge clk156);
    if (!reset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (sready_watch && !s_tready) sready_low = 1'b1;
      if (hold_pend && ({m_tvalid, m_tlast, m_tkeep, m_tdata} !== hold_val)) stall_bad++;
      hold_pend = m_tvalid && !m_tready;
      hold_val  = {m_tvalid, m_tlast, m_tkeep, m_tdata};
      if (m_tvalid && m_tready) begin
        got_q.push_back({m_tlast, m_tkeep, m_tdata});
        hs_cyc_q.push_back(cyc);
      end
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected finish", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int budget;

    repeat (3) @(posedge clk156);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_stat_tx", stat_tx, 0);
    chk("rst_stat_drop", stat_drop, 0);
    reset_n = 1'b1;
    @(posedge clk156);
    #1;
    chk("rel_s_tready", s_tready, 1);
    sready_watch = 1'b1;

    // Single 60-byte frame and commit-to-valid latency
    base = got_q.size();
    exp_q.delete();
    send_frame(1, 8, 8'h0F, 1'b0, 1'b1);
    chk("lat_t0", m_tvalid, 0);
    @(posedge clk156);
    #1;
    chk("lat_t1", m_tvalid, 0);
    @(posedge clk156);
    #1;
    chk("lat_t2", m_tvalid, 1);
    chk("m_tuser_zero", m_tuser, 0);
    wait_out(base, 8);
    cmp_frames("single", base);
    chk("single_stat_tx", stat_tx, 1);

    // Three back-to-back frames, no gaps in or out
    base = got_q.size();
    exp_q.delete();
    send_frame(10, 8, 8'h01, 1'b0, 1'b1);
    send_frame(11, 8, 8'h3F, 1'b0, 1'b1);
    send_frame(12, 8, 8'hFF, 1'b0, 1'b1);
    wait_out(base, 24);
    cmp_frames("b2b", base);
    if (hs_cyc_q.size() >= base + 24)
      chk("b2b_span", hs_cyc_q[base + 23] - hs_cyc_q[base], 23);
    chk("b2b_avail", dut.frames_avail_q, 0);
    chk("b2b_stat_tx", stat_tx, 4);

    // Random backpressure over four frames of varying length
    rdy_rand = 1'b1;
    base = got_q.size();
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      send_frame(20 + k, 5 + k, 8'h07 << k, 1'b0, 1'b1);
      budget = 300;
      while ((stat_tx < 32'(5 + k)) && (budget > 0)) begin
        @(posedge clk156);
        budget--;
      end
      #1;
    end
    wait_out(base, 26);
    rdy_rand = 1'b0;
    cmp_frames("bp", base);
    chk("bp_stat_tx", stat_tx, 8);
    chk("bp_stall_hold", stall_bad, 0);

    // Overflow: 16 beats cannot fit in 15 usable words
    repeat (4) @(posedge clk156);
    #1;
    base = got_q.size();
    exp_q.delete();
    send_frame(30, 16, 8'hFF, 1'b0, 1'b0);
    repeat (12) @(posedge clk156);
    #1;
    chk("ovf_no_out", got_q.size() - base, 0);
    chk("ovf_stat_drop", stat_drop, 1);
    send_frame(31, 8, 8'h0F, 1'b0, 1'b1);
    wait_out(base, 8);
    cmp_frames("ovf_next", base);
    chk("ovf_stat_tx", stat_tx, 9);

    // Frame flagged bad by tuser on its last beat
    base = got_q.size();
    exp_q.delete();
    send_frame(40, 8, 8'h0F, 1'b1, 1'b0);
    repeat (12) @(posedge clk156);
    #1;
    chk("tuser_no_out", got_q.size() - base, 0);
    chk("tuser_stat_drop", stat_drop, 2);
    send_frame(41, 8, 8'h03, 1'b0, 1'b1);
    wait_out(base, 8);
    cmp_frames("tuser_next", base);
    chk("tuser_stat_tx", stat_tx, 10);
    chk("s_tready_held", sready_low, 0);
    sready_watch = 1'b0;

    // Reset with one frame partly out and the next partly in
    base = got_q.size();
    exp_q.delete();
    send_frame(50, 8, 8'h0F, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive_beat(beat(51, i, 8, 8'hFF), 1'b0);
    reset_n  = 1'b0;
    s_tvalid = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tlast", m_tlast, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    chk("mid_rst_m_tkeep", m_tkeep, 0);
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_stat_tx", stat_tx, 0);
    chk("mid_rst_stat_drop", stat_drop, 0);
    chk("mid_rst_out_cnt", got_q.size() - base, 2);
    if (got_q.size() >= base + 2) begin
      chk("mid_rst_b0", got_q[base], exp_q[0]);
      chk("mid_rst_b1", got_q[base + 1], exp_q[1]);
    end
    repeat (2) @(posedge clk156);
    #1;
    reset_n = 1'b1;
    @(posedge clk156);
    #1;
    chk("post_rst_s_tready", s_tready, 1);
    base = got_q.size();
    exp_q.delete();
    send_frame(60, 8, 8'h0F, 1'b0, 1'b1);
    wait_out(base, 8);
    cmp_frames("post_rst", base);
    chk("post_rst_stat_tx", stat_tx, 1);
    chk("post_rst_stat_drop", stat_drop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
